// File: rtl/n_bit_csa_pkg.sv
// Shared constants and helpers for the carry-select subtractor.
package n_bit_csa_pkg;

    localparam int DEFAULT_BLOCK_WIDTH = 2;

    // Number of carry-select blocks needed to cover 'width' bits in
    // steps of 'blk' (the last block may be short).
    function automatic int num_blocks(input int width, input int blk);
        return (width + blk - 1) / blk;
    endfunction

endpackage

// File: rtl/csa_ripple_block.sv
// One ripple-carry adder slice used as a building block of the
// carry-select adder: s = a + b + ci, co = carry out of the MSB.
module csa_ripple_block #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // Bit-serial ripple of the carry through the slice.
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        co = c;
    end

endmodule

// File: rtl/n_bit_csa_subtractor.sv
// Registered unsigned subtractor with borrow-in: sum = in1 - in2 - cin,
// produced as an (N+1)-bit two's-complement word via a carry-select
// adder computing {0,in1} + ~{0,in2} + ~cin.
// Optional macro N_BIT_CSA_SUB_VALID_EN adds in_valid/out_valid; without
// it sum updates on every clock edge.
module n_bit_csa_subtractor
    import n_bit_csa_pkg::*;
#(
    parameter int IN_DATAWIDTH  = 4,
    parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
    parameter int BLOCK_WIDTH   = DEFAULT_BLOCK_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef N_BIT_CSA_SUB_VALID_EN
    input  logic                     in_valid,
    output logic                     out_valid,
`endif
    input  logic [IN_DATAWIDTH-1:0]  in1,
    input  logic [IN_DATAWIDTH-1:0]  in2,
    input  logic                     cin,
    output logic [OUT_DATAWIDTH-1:0] sum
);

    localparam int NB = num_blocks(OUT_DATAWIDTH, BLOCK_WIDTH);

    logic [OUT_DATAWIDTH-1:0] a;
    logic [OUT_DATAWIDTH-1:0] b;
    logic [OUT_DATAWIDTH-1:0] sum_comb;
    logic [NB:0]              carry;
    logic                     unused_carry;

    assign a            = {1'b0, in1};
    assign b            = ~{1'b0, in2};
    assign carry[0]     = ~cin;
    // Final carry-out is meaningless for the (N+1)-bit result.
    assign unused_carry = carry[NB];

    for (genvar i = 0; i < NB; i++) begin : g_blk
        localparam int LO = i * BLOCK_WIDTH;
        localparam int BW = ((OUT_DATAWIDTH - LO) < BLOCK_WIDTH) ? (OUT_DATAWIDTH - LO) : BLOCK_WIDTH;

        if (i == 0) begin : g_first
            csa_ripple_block #(.WIDTH(BW)) u_blk (
                .a  (a[LO +: BW]),
                .b  (b[LO +: BW]),
                .ci (carry[0]),
                .s  (sum_comb[LO +: BW]),
                .co (carry[1])
            );
        end else begin : g_sel
            logic [BW-1:0] s0;
            logic [BW-1:0] s1;
            logic          co0;
            logic          co1;

            csa_ripple_block #(.WIDTH(BW)) u_blk0 (
                .a  (a[LO +: BW]),
                .b  (b[LO +: BW]),
                .ci (1'b0),
                .s  (s0),
                .co (co0)
            );

            csa_ripple_block #(.WIDTH(BW)) u_blk1 (
                .a  (a[LO +: BW]),
                .b  (b[LO +: BW]),
                .ci (1'b1),
                .s  (s1),
                .co (co1)
            );

            // Previous block's carry picks the precomputed result.
            assign sum_comb[LO +: BW] = carry[i] ? s1 : s0;
            assign carry[i+1]         = carry[i] ? co1 : co0;
        end
    end

`ifdef N_BIT_CSA_SUB_VALID_EN
    // Output register: reset clears, otherwise capture only on in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= sum_comb;
            end
        end
    end
`else
    // Output register: reset clears, otherwise capture every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= sum_comb;
        end
    end
`endif

endmodule

// File: tb/tb_n_bit_csa_subtractor.sv
// Scoreboard bench for n_bit_csa_subtractor (N=4). Honours
// N_BIT_CSA_SUB_VALID_EN when the design is built with it.
module tb_n_bit_csa_subtractor;

    logic       clk;
    logic       rst;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       cin;
    logic [4:0] sum;
`ifdef N_BIT_CSA_SUB_VALID_EN
    logic       in_valid;
    logic       out_valid;
`endif

    int checks = 0;
    int errors = 0;

    // {expected out_valid, expected sum}
    logic [5:0] exp_q[$];
    string      name_q[$];

    logic [4:0] model_sum = '0;

    n_bit_csa_subtractor #(
        .IN_DATAWIDTH (4),
        .BLOCK_WIDTH  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef N_BIT_CSA_SUB_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector at the falling edge and queue what the next rising
    // edge must produce.
    task automatic step(input logic [3:0] i1, input logic [3:0] i2, input logic c,
                        input logic r, input logic v, input logic [4:0] exp_s,
                        input string nm);
        logic ov;
        @(negedge clk);
        in1 = i1;
        in2 = i2;
        cin = c;
        rst = r;
`ifdef N_BIT_CSA_SUB_VALID_EN
        in_valid = v;
        ov = r ? 1'b0 : v;
        if (r) model_sum = '0;
        else if (v) model_sum = exp_s;
`else
        ov = 1'b1;
        if (r) model_sum = '0;
        else model_sum = exp_s;
`endif
        exp_q.push_back({ov, model_sum});
        name_q.push_back(nm);
    endtask

    // Monitor: compare just after each rising edge whenever a result is due.
    initial begin
        logic [5:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (sum !== e[4:0]) begin
                    errors++;
                    $display("FAIL %s: sum=%b expected %b (in1=%0d in2=%0d cin=%0d)",
                             nm, sum, e[4:0], in1, in2, cin);
                end
`ifdef N_BIT_CSA_SUB_VALID_EN
                checks++;
                if (out_valid !== e[5]) begin
                    errors++;
                    $display("FAIL %s_valid: out_valid=%b expected %b", nm, out_valid, e[5]);
                end
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in1 = 4'd9;
        in2 = 4'd3;
        cin = 1'b0;
`ifdef N_BIT_CSA_SUB_VALID_EN
        in_valid = 1'b1;
`endif
        // Reset held two edges, then first result
        step(4'd9, 4'd3, 1'b0, 1'b1, 1'b1, 5'd0, "reset0");
        step(4'd9, 4'd3, 1'b0, 1'b1, 1'b1, 5'd0, "reset1");
        step(4'd9, 4'd3, 1'b0, 1'b0, 1'b1, 5'd6, "release");

        // Negative extremes
        step(4'd0,  4'd0,  1'b1, 1'b0, 1'b1, 5'b11111, "zero_borrow");
        step(4'd0,  4'd15, 1'b0, 1'b0, 1'b1, 5'b10001, "neg15");

        // Positive extremes
        step(4'd15, 4'd0,  1'b0, 1'b0, 1'b1, 5'b01111, "pos15");
        step(4'd15, 4'd15, 1'b1, 1'b0, 1'b1, 5'b11111, "max_borrow");
        step(4'd0,  4'd15, 1'b1, 1'b0, 1'b1, 5'b10000, "most_neg");

        // Exhaustive sweep against the arithmetic identity
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int c = 0; c < 2; c++)
                    step(4'(i), 4'(j), 1'(c), 1'b0, 1'b1, 5'(i - j - c), "exh");

        // Mid-stream reset, then fresh results only
        step(4'd7, 4'd2, 1'b0, 1'b1, 1'b1, 5'd0,     "mid_reset");
        step(4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 5'b11110, "post_reset");
        step(4'd7, 4'd2, 1'b0, 1'b0, 1'b1, 5'd5,     "post_reset2");

`ifdef N_BIT_CSA_SUB_VALID_EN
        // Hold while in_valid is low, then accept 4-6
        step(4'd1,  4'd9, 1'b0, 1'b0, 1'b0, 5'd0,     "hold0");
        step(4'd12, 4'd2, 1'b1, 1'b0, 1'b0, 5'd0,     "hold1");
        step(4'd4,  4'd6, 1'b0, 1'b0, 1'b1, 5'b11110, "valid_4_6");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
